// File: rtl/timekeeper_pkg.sv
// -----------------------------------------------------------------------------
// timekeeper_pkg
// Shared constants and helpers for the timekeeper core:
//   - field limits for seconds, minutes and hours (binary)
//   - set_sel encodings selecting which field the set key increments
//   - two-digit BCD struct used by the display path
//   - 24 h -> 12 h hour conversion used for the display only
// -----------------------------------------------------------------------------
package timekeeper_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SEC  = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_HOUR = 2'd3
    } set_sel_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Midnight reads 12, 1..12 unchanged, 13..23 fold down by twelve.
    function automatic logic [4:0] hour_to_12h(input logic [4:0] hour);
        logic [4:0] h12;
        if (hour == 5'd0) begin
            h12 = 5'd12;
        end else if (hour > 5'd12) begin
            h12 = hour - 5'd12;
        end else begin
            h12 = hour;
        end
        return h12;
    endfunction

endpackage

// File: rtl/timekeeper_param_bin2bcd2.sv
// -----------------------------------------------------------------------------
// bin2bcd2
// Combinational 6-bit binary (0-59) to two BCD digits.
// Ports:
//   bin  in   6-bit binary value, valid range 0..59
//   bcd  out  tens/ones BCD digits
// Inputs above 59 are never presented by the timekeeper; they land in the
// 50s bucket with a meaningless ones digit.
// -----------------------------------------------------------------------------
module bin2bcd2
    import timekeeper_pkg::*;
(
    input  logic [5:0] bin,
    output bcd2_t      bcd
);

    always_comb begin
        // NOTE: every output gets a value on every path through this block;
        // a branch that left one unassigned would infer a latch.
        bcd = '0;
        if (bin >= 6'd50) begin
            bcd.tens = 4'd5;
            bcd.ones = 4'(bin - 6'd50);
        end else if (bin >= 6'd40) begin
            bcd.tens = 4'd4;
            bcd.ones = 4'(bin - 6'd40);
        end else if (bin >= 6'd30) begin
            bcd.tens = 4'd3;
            bcd.ones = 4'(bin - 6'd30);
        end else if (bin >= 6'd20) begin
            bcd.tens = 4'd2;
            bcd.ones = 4'(bin - 6'd20);
        end else if (bin >= 6'd10) begin
            bcd.tens = 4'd1;
            bcd.ones = 4'(bin - 6'd10);
        end else begin
            bcd.tens = 4'd0;
            bcd.ones = 4'(bin);
        end
    end

endmodule

// File: rtl/timekeeper_param.sv
// -----------------------------------------------------------------------------
// timekeeper_param
// Fully synchronous seconds/minutes/hours timekeeper with a one-second
// prescaler, 12/24 h display, per-field setting and a minute-resolution alarm.
// Parameters:
//   CLK_HZ     clock cycles per second (>= 2)
//   ALARM_LEN  seconds the alarm stays high unless acknowledged (>= 1)
// Ports:
//   CLOCK_50   in   system clock
//   rst        in   synchronous active-high reset
//   run        in   1 = prescaler and time advance
//   mode_12h   in   1 = 12 h display, 0 = 24 h display
//   set_sel    in   field to set: 0 none, 1 sec, 2 min, 3 hour
//   set_inc    in   level key; each rising edge bumps the selected field
//   alarm_en   in   alarm armed
//   alarm_hour in   alarm hour 0..23 (binary)
//   alarm_min  in   alarm minute 0..59 (binary)
//   alarm_ack  in   clears an active alarm
//   *_ones/*_tens out  registered BCD display digits
//   pm         out  registered, 12 h mode and hour >= 12
//   tick       out  registered one-cycle pulse per elapsed second
//   alarm      out  alarm active
// -----------------------------------------------------------------------------
module timekeeper_param
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int ALARM_LEN = 60
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_12h,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic       pm,
    output logic       tick,
    output logic       alarm
);

    localparam int PRESC_W = $clog2(CLK_HZ);
    localparam int HOLD_W  = $clog2(ALARM_LEN + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(ALARM_LEN);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    // ---------------------------------------------------------------- state
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         sec_q,   sec_d;
    logic [5:0]         min_q,   min_d;
    logic [4:0]         hour_q,  hour_d;
    logic               inc_s1_q, inc_s1_d;
    logic               inc_s2_q, inc_s2_d;
    logic               alarm_q, alarm_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic               tick_q,  tick_d;
    logic               pm_q,    pm_d;
    bcd2_t              sec_bcd_q,  sec_bcd_d;
    bcd2_t              min_bcd_q,  min_bcd_d;
    bcd2_t              hour_bcd_q, hour_bcd_d;

    set_sel_e   sel;
    logic       tick_c;
    logic       inc_p;
    logic       alarm_hit;
    logic [4:0] hour_disp;

    assign sel = set_sel_e'(set_sel);

    // Any set selection freezes the prescaler, so seconds cannot tick while
    // the user is editing a field.
    assign tick_c = (presc_q == PRESC_LAST) & run & (sel == SEL_NONE);

    // set_inc is first registered, then edge-detected against a second stage,
    // which places the field update one cycle after the key rises.
    assign inc_p = inc_s1_q & ~inc_s2_q;

    // ------------------------------------------------- prescaler and time
    always_comb begin
        presc_d  = presc_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        inc_s1_d = set_inc;
        inc_s2_d = inc_s1_q;

        if (sel != SEL_NONE) begin
            presc_d = '0;
            if (inc_p) begin
                // Field-local wrap: no carry into neighbouring fields.
                case (sel)
                    SEL_SEC:  sec_d  = (sec_q  == SEC_MAX)  ? 6'd0 : sec_q  + 6'd1;
                    SEL_MIN:  min_d  = (min_q  == MIN_MAX)  ? 6'd0 : min_q  + 6'd1;
                    SEL_HOUR: hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                    default:  ;
                endcase
            end
        end else if (run) begin
            if (tick_c) begin
                presc_d = '0;
                // Full carry chain resolves in one edge.
                if (sec_q == SEC_MAX) begin
                    sec_d = 6'd0;
                    if (min_q == MIN_MAX) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- alarm
    // Compared against the post-increment time so the alarm fires on the edge
    // that enters hh:mm:00. Only tick_c can trigger, never a set edit.
    assign alarm_hit = tick_c & alarm_en & (sec_d == 6'd0)
                     & (min_d == alarm_min) & (hour_d == alarm_hour);

    always_comb begin
        alarm_d = alarm_q;
        hold_d  = hold_q;
        if (alarm_ack || !alarm_en) begin
            // Clearing has priority over a same-cycle trigger.
            alarm_d = 1'b0;
            hold_d  = '0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
            hold_d  = HOLD_LOAD;
        end else if (alarm_q && tick_c) begin
            if (hold_q <= HOLD_ONE) begin
                alarm_d = 1'b0;
                hold_d  = '0;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    // --------------------------------------------------------------- display
    always_comb begin
        hour_disp = mode_12h ? hour_to_12h(hour_q) : hour_q;
        pm_d      = mode_12h & (hour_q >= 5'd12);
        tick_d    = tick_c;
    end

    bin2bcd2 u_sec_bcd (
        .bin (sec_q),
        .bcd (sec_bcd_d)
    );

    bin2bcd2 u_min_bcd (
        .bin (min_q),
        .bcd (min_bcd_d)
    );

    bin2bcd2 u_hour_bcd (
        .bin ({1'b0, hour_disp}),
        .bcd (hour_bcd_d)
    );

    // ------------------------------------------------------------- registers
    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (rst) begin
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            inc_s1_q   <= 1'b0;
            inc_s2_q   <= 1'b0;
            alarm_q    <= 1'b0;
            hold_q     <= '0;
            tick_q     <= 1'b0;
            pm_q       <= 1'b0;
            sec_bcd_q  <= '0;
            min_bcd_q  <= '0;
            hour_bcd_q <= '0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            inc_s1_q   <= inc_s1_d;
            inc_s2_q   <= inc_s2_d;
            alarm_q    <= alarm_d;
            hold_q     <= hold_d;
            tick_q     <= tick_d;
            pm_q       <= pm_d;
            sec_bcd_q  <= sec_bcd_d;
            min_bcd_q  <= min_bcd_d;
            hour_bcd_q <= hour_bcd_d;
        end
    end

    assign sec_ones  = sec_bcd_q.ones;
    assign sec_tens  = sec_bcd_q.tens;
    assign min_ones  = min_bcd_q.ones;
    assign min_tens  = min_bcd_q.tens;
    assign hour_ones = hour_bcd_q.ones;
    assign hour_tens = hour_bcd_q.tens;
    assign pm        = pm_q;
    assign tick      = tick_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_timekeeper_param.sv
// -----------------------------------------------------------------------------
// tb_timekeeper_param
// Directed bench for timekeeper_param with CLK_HZ = 4 and ALARM_LEN = 3.
// Display digits are packed as {hh, mm, ss} BCD so an expected time reads
// naturally as a hex literal, e.g. 24'h235959.
// -----------------------------------------------------------------------------
module tb_timekeeper_param;
    import timekeeper_pkg::*;

    localparam int CLK_HZ    = 4;
    localparam int ALARM_LEN = 3;

    logic       CLOCK_50   = 1'b0;
    logic       rst        = 1'b1;
    logic       run        = 1'b0;
    logic       mode_12h   = 1'b0;
    logic [1:0] set_sel    = 2'd0;
    logic       set_inc    = 1'b0;
    logic       alarm_en   = 1'b0;
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_min  = 6'd0;
    logic       alarm_ack  = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic       pm, tick, alarm;
    logic [23:0] digits;

    int vectors     = 0;
    int miscompares = 0;
    int tick_cnt    = 0;

    assign digits = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};

    timekeeper_param #(
        .CLK_HZ    (CLK_HZ),
        .ALARM_LEN (ALARM_LEN)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .run        (run),
        .mode_12h   (mode_12h),
        .set_sel    (set_sel),
        .set_inc    (set_inc),
        .alarm_en   (alarm_en),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_ack  (alarm_ack),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .hour_ones  (hour_ones),
        .hour_tens  (hour_tens),
        .pm         (pm),
        .tick       (tick),
        .alarm      (alarm)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (tick === 1'b1) tick_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ utilities
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (tick !== 1'b1 && cycles < 50);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        set_sel   = SEL_NONE;
        set_inc   = 1'b0;
        alarm_ack = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic set_field(input logic [1:0] sel, input int n);
        set_sel = sel;
        repeat (n) begin
            set_inc = 1'b1;
            step(1);
            set_inc = 1'b0;
            step(1);
        end
    endtask

    // Resets, then edits the fields up from 00:00:00; returns with set_sel = 0
    // in the cycle where the prescaler starts from zero.
    task automatic set_time(input int h, input int m, input int s);
        apply_reset();
        set_field(SEL_HOUR, h);
        set_field(SEL_MIN, m);
        set_field(SEL_SEC, s);
        set_sel = SEL_NONE;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; run = 1'b1; mode_12h = 1'b1;
        step(2);
        vectors++;
        if (digits !== 24'h000000 || tick !== 1'b0 || alarm !== 1'b0 || pm !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: digits=%h tick=%b alarm=%b pm=%b, expected 000000 0 0 0",
                     digits, tick, alarm, pm);
        end
        rst = 1'b0;
        step(1);
        vectors++;
        if (digits !== 24'h120000 || pm !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_12h: digits=%h pm=%b, expected 120000 0", digits, pm);
        end
    endtask

    task automatic test_counting();
        int cyc, last, ticks, seen;
        mode_12h = 1'b0; run = 1'b1;
        apply_reset();
        cyc = 0; last = 0; ticks = 0;
        while (ticks < 60 && cyc < 1000) begin
            step(1);
            cyc++;
            if (tick === 1'b1) begin
                vectors++;
                if (cyc - last != CLK_HZ) begin
                    miscompares++;
                    $display("FAIL tick_period: tick %0d after %0d cycles, expected %0d",
                             ticks, cyc - last, CLK_HZ);
                end
                last = cyc;
                ticks++;
            end
        end
        vectors++;
        if (ticks != 60) begin
            miscompares++;
            $display("FAIL tick_count: saw %0d ticks, expected 60", ticks);
        end
        step(1);
        vectors++;
        if (digits !== 24'h000100) begin
            miscompares++;
            $display("FAIL count_60s: digits=%h, expected 000100", digits);
        end
        run = 1'b0;
        seen = 0;
        repeat (20) begin
            step(1);
            if (tick === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || digits !== 24'h000100) begin
            miscompares++;
            $display("FAIL run_freeze: ticks=%0d digits=%h, expected 0 000100", seen, digits);
        end
    endtask

    task automatic test_rollover();
        int cyc;
        mode_12h = 1'b0; run = 1'b1;
        set_time(23, 59, 59);
        step(1);
        vectors++;
        if (digits !== 24'h235959) begin
            miscompares++;
            $display("FAIL set_235959: digits=%h, expected 235959", digits);
        end
        wait_tick(cyc);
        vectors++;
        if (tick !== 1'b1 || cyc != 3 || digits !== 24'h235959) begin
            miscompares++;
            $display("FAIL rollover_n1: tick=%b cycles=%0d digits=%h, expected 1 3 235959",
                     tick, cyc, digits);
        end
        step(1);
        vectors++;
        if (tick !== 1'b0 || digits !== 24'h000000) begin
            miscompares++;
            $display("FAIL rollover_n2: tick=%b digits=%h, expected 0 000000", tick, digits);
        end
    endtask

    task automatic test_12h();
        run = 1'b0; mode_12h = 1'b1;
        set_time(12, 0, 0);
        step(1);
        vectors++;
        if (digits[23:16] !== 8'h12 || pm !== 1'b1) begin
            miscompares++;
            $display("FAIL h12_noon: hour=%h pm=%b, expected 12 1", digits[23:16], pm);
        end
        set_field(SEL_HOUR, 1);
        step(1);
        vectors++;
        if (digits[23:16] !== 8'h01 || pm !== 1'b1) begin
            miscompares++;
            $display("FAIL h12_13: hour=%h pm=%b, expected 01 1", digits[23:16], pm);
        end
        mode_12h = 1'b0;
        vectors++;
        if (digits[23:16] !== 8'h01 || pm !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_delay: hour=%h pm=%b, expected 01 1", digits[23:16], pm);
        end
        step(1);
        vectors++;
        if (digits[23:16] !== 8'h13 || pm !== 1'b0) begin
            miscompares++;
            $display("FAIL h24_13: hour=%h pm=%b, expected 13 0", digits[23:16], pm);
        end
        set_sel = SEL_NONE;
    endtask

    task automatic test_set_mode();
        int t0;
        mode_12h = 1'b0; run = 1'b1;
        apply_reset();
        t0 = tick_cnt;
        set_sel = SEL_MIN;
        set_inc = 1'b1;
        step(10);
        set_inc = 1'b0;
        step(3);
        vectors++;
        if (digits !== 24'h000100) begin
            miscompares++;
            $display("FAIL held_inc: digits=%h, expected 000100", digits);
        end
        set_field(SEL_HOUR, 5);
        set_field(SEL_MIN, 58);
        step(1);
        vectors++;
        if (digits !== 24'h055900) begin
            miscompares++;
            $display("FAIL set_0559: digits=%h, expected 055900", digits);
        end
        set_field(SEL_MIN, 1);
        step(1);
        vectors++;
        if (digits !== 24'h050000) begin
            miscompares++;
            $display("FAIL min_wrap: digits=%h, expected 050000", digits);
        end
        set_field(SEL_SEC, 59);
        step(1);
        vectors++;
        if (digits !== 24'h050059) begin
            miscompares++;
            $display("FAIL set_sec59: digits=%h, expected 050059", digits);
        end
        set_field(SEL_SEC, 1);
        step(1);
        vectors++;
        if (digits !== 24'h050000) begin
            miscompares++;
            $display("FAIL sec_wrap: digits=%h, expected 050000", digits);
        end
        vectors++;
        if (tick_cnt != t0) begin
            miscompares++;
            $display("FAIL set_no_tick: %0d ticks during set, expected 0", tick_cnt - t0);
        end
        run = 1'b0;
        set_sel = SEL_NONE;
        set_inc = 1'b1;
        step(1);
        set_inc = 1'b0;
        step(3);
        vectors++;
        if (digits !== 24'h050000) begin
            miscompares++;
            $display("FAIL inc_no_sel: digits=%h, expected 050000", digits);
        end
    endtask

    task automatic test_alarm();
        int cyc;
        mode_12h = 1'b0; run = 1'b1;
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;

        set_time(7, 30, 0);
        step(6);
        vectors++;
        if (alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL set_onto_alarm: alarm=%b, expected 0", alarm);
        end

        set_time(7, 29, 59);
        step(3);
        vectors++;
        if (alarm !== 1'b0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL alarm_pre: alarm=%b tick=%b, expected 0 0", alarm, tick);
        end
        step(1);
        vectors++;
        if (alarm !== 1'b1 || tick !== 1'b1) begin
            miscompares++;
            $display("FAIL alarm_trigger: alarm=%b tick=%b, expected 1 1", alarm, tick);
        end
        step(1);
        vectors++;
        if (digits !== 24'h073000) begin
            miscompares++;
            $display("FAIL alarm_time: digits=%h, expected 073000", digits);
        end
        for (int k = 1; k <= 3; k++) begin
            wait_tick(cyc);
            vectors++;
            if (tick !== 1'b1 || alarm !== (k < 3)) begin
                miscompares++;
                $display("FAIL alarm_hold_%0d: tick=%b alarm=%b, expected 1 %0d",
                         k, tick, alarm, (k < 3));
            end
        end

        set_time(7, 29, 59);
        step(3);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        vectors++;
        if (tick !== 1'b1 || alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_in_trigger: tick=%b alarm=%b, expected 1 0", tick, alarm);
        end
        step(2);
        vectors++;
        if (alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_stays_low: alarm=%b, expected 0", alarm);
        end

        set_time(7, 29, 59);
        step(4);
        vectors++;
        if (alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL alarm_retrigger: alarm=%b, expected 1", alarm);
        end
        alarm_en = 1'b0;
        step(1);
        vectors++;
        if (alarm !== 1'b0) begin
            miscompares++;
            $display("FAIL alarm_disarm: alarm=%b, expected 0", alarm);
        end
        alarm_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        mode_12h = 1'b0; run = 1'b1;
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        set_time(7, 29, 59);
        step(4);
        vectors++;
        if (alarm !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_alarm_up: alarm=%b, expected 1", alarm);
        end
        mode_12h = 1'b1;
        set_sel  = SEL_HOUR;
        set_inc  = 1'b1;
        rst      = 1'b1;
        step(1);
        vectors++;
        if (alarm !== 1'b0 || tick !== 1'b0 || digits !== 24'h000000 || pm !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: alarm=%b tick=%b digits=%h pm=%b, expected 0 0 000000 0",
                     alarm, tick, digits, pm);
        end
        rst = 1'b0; set_sel = SEL_NONE; set_inc = 1'b0; mode_12h = 1'b0;
        wait_tick(cyc);
        vectors++;
        if (tick !== 1'b1 || cyc != CLK_HZ) begin
            miscompares++;
            $display("FAIL resume_tick: tick=%b cycles=%0d, expected 1 %0d", tick, cyc, CLK_HZ);
        end
        step(1);
        vectors++;
        if (digits !== 24'h000001) begin
            miscompares++;
            $display("FAIL resume_count: digits=%h, expected 000001", digits);
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_rollover();
        test_12h();
        test_set_mode();
        test_alarm();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timekeeper_param.md
# timekeeper_param

Parametrised single-clock timekeeping core for the board-level digital clock. It replaces ripple-clocked second/minute/hour counters with a fully synchronous design driven by one prescaler tick. It also adds 12/24-hour display mode, per-field time setting and a minute-resolution alarm. It sits between the board clock/keys/switches and the seven-segment decoders, and outputs six BCD digits ready for the HEX drivers.

## Interface
- CLK_HZ, 50_000_000, input clock cycles per second; must be ≥ 2; prescaler width is $clog2(CLK_HZ).
- ALARM_LEN, 60, seconds the alarm output stays high if not acknowledged; must be ≥ 1.

- CLOCK_50  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = time advances; 0 = prescaler and time frozen.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- set_sel  in  2  0 none, 1 seconds, 2 minutes, 3 hours.
- set_inc  in  1  level input; each rising edge increments the selected field.
- alarm_en  in  1  alarm arm.
- alarm_hour  in  5  alarm hour, binary 0–23.
- alarm_min  in  6  alarm minute, binary 0–59.
- alarm_ack  in  1  clears an active alarm.
- sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens  out  4 each  BCD display digits.
- pm  out  1  high in 12 h mode when hour ≥ 12; 0 in 24 h mode.
- tick  out  1  one-cycle pulse per elapsed second.
- alarm  out  1  alarm active.

## Operation
- State: presc counts 0..CLK_HZ-1; sec 0–59, min 0–59 and hour 0–23 are held in binary.
- tick_c = (presc == CLK_HZ-1) & run & (set_sel == 0).
- presc behaviour:
  - Increments when run = 1 and set_sel = 0.
  - Wraps to 0 on tick_c.
  - Is held at 0 whenever set_sel ≠ 0.
- On tick_c:
  - sec increments.
  - sec 59→0 carries into min; min 59→0 carries into hour; hour 23→0.
  - All carries resolve in the same edge.
- Set mode:
  - The block registers set_inc and detects its rising edge (inc_p).
  - When inc_p = 1 and set_sel ≠ 0, the selected field increments modulo its range with no carry into other fields.
  - inc_p with set_sel = 0 is ignored.
- Display conversion:
  - 24 h mode: hour_tens/hour_ones = BCD(hour).
  - 12 h mode: hour 0 displays 12; hours 1–12 display unchanged; hours 13–23 display hour−12.
  - pm = mode_12h & (hour ≥ 12).
- Alarm trigger:
  - Triggers on tick_c when the post-increment time is alarm_hour:alarm_min:00 and alarm_en = 1.
  - Setting the time onto the alarm time never triggers.
- On trigger: alarm = 1 and the hold counter loads ALARM_LEN.
- While alarm = 1, each subsequent tick_c decrements the hold counter; the alarm clears when the counter reaches 0.
- Alarm clear conditions: alarm_ack = 1, alarm_en = 0, or hold expiry.
- Simultaneous trigger and ack or alarm_en = 0: clear wins, so alarm stays 0.
- Mode change (mode_12h) takes effect on the digits one cycle later; the time state is unaffected.
- Reset (any cycle, including mid-set or mid-alarm):
  - presc, sec, min and hour go to 0; the set_inc edge register goes to 0.
  - alarm = 0, tick = 0, all digits = 0, pm = 0.

## Timing
- Cycle N has tick_c = 1; the time registers update at the end of N.
- tick output is registered: high during N+1 only.
- Digits and pm are registered from the time state: they show the new time during N+2.
- alarm is registered alongside the time state: high from N+1.
- Set edges: set_inc rises in cycle M, field updates at the end of M+1, and digits change in M+3.
- First cycle after reset release: digits show the converted 00:00:00 (hour 12 in 12 h mode).
- Tick period with run = 1 and set_sel = 0 is exactly CLK_HZ cycles.

## Structure
- Package timekeeper_pkg holds:
  - SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
  - The set_sel encodings SEL_NONE/SEL_SEC/SEL_MIN/SEL_HOUR.
  - The 12 h conversion function.
- One sub-module, bin2bcd2: combinational 6-bit binary (0–59) to two BCD digits, instantiated three times.
- Estimated size: ~200 lines of RTL.

## Test plan
- **Counting:** CLK_HZ = 4, run = 1, 24 h, release rst → tick every 4 cycles; after 60 ticks digits read 00:01:00; run = 0 for 20 cycles → no tick, digits frozen.
- **Full rollover:** set time to 23:59:59 → next tick gives digits 00:00:00 in N+2, with tick high in N+1 only.
- **12 h mode:**
  - hour 0 → digits 12, pm = 0.
  - hour 12 → 12, pm = 1.
  - hour 13 → 01, pm = 1.
  - Switch to 24 h → 13, pm = 0, one cycle later.
- **Set mode:**
  - set_sel = 2 with set_inc held high for 10 cycles → minutes +1 only.
  - min 59 plus inc → 00 with hour unchanged.
  - Seconds frozen and no tick while set_sel ≠ 0.
- **Alarm:**
  - ALARM_LEN = 3, alarm 07:30, time 07:29:59 → alarm high from N+1; drops after the third subsequent tick.
  - Repeat with alarm_ack asserted in the trigger cycle → alarm never rises.
- **Reset mid-operation:** rst asserted with alarm = 1 and set_sel = 3 → next cycle alarm = 0, tick = 0, all digits 0, pm = 0; counting resumes from 00:00:00.
